// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the CDC read-side packer.
// Provides the default entry width and the count-port width function.
package cdc_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  function automatic int cnt_w(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/cdc_rd_packer_if.sv
// Read-port bundle: FIFO pop side, flush request and packed word output.
// master: packer view (drives re/word/cnt/valid); slave: FIFO + sink view.
interface cdc_rd_packer_if
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK       = 4
) ();

  localparam int CNT_W = cnt_w(PACK);

  logic                       cB_rrdy_i;
  logic                       cB_re_o;
  logic [DATA_WIDTH-1:0]      cB_din_i;
  logic                       cB_flush_i;
  logic [DATA_WIDTH*PACK-1:0] cB_word_o;
  logic [CNT_W-1:0]           cB_cnt_o;
  logic                       cB_valid_o;
  logic                       cB_ready_i;

  modport master (
    input  cB_rrdy_i,
    input  cB_din_i,
    input  cB_flush_i,
    input  cB_ready_i,
    output cB_re_o,
    output cB_word_o,
    output cB_cnt_o,
    output cB_valid_o
  );

  modport slave (
    output cB_rrdy_i,
    output cB_din_i,
    output cB_flush_i,
    output cB_ready_i,
    input  cB_re_o,
    input  cB_word_o,
    input  cB_cnt_o,
    input  cB_valid_o
  );

endinterface

// File: rtl/cdc_rd_packer.sv
// Packs PACK FIFO entries (1-cycle read latency) into one valid/ready word.
// Ports: clkB_i, cB_rst_ni (async low), bus (FIFO pop, flush, word out).
module cdc_rd_packer
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK       = 4
) (
  input  logic              clkB_i,
  input  logic              cB_rst_ni,
  cdc_rd_packer_if.master   bus
);

  localparam int CNT_W = cnt_w(PACK);
  localparam int LW    = $clog2(PACK);
  localparam int LAST  = PACK - 1;

  typedef logic [PACK-1:0][DATA_WIDTH-1:0] word_t;

  word_t            acc;
  word_t            full_word;
  logic [CNT_W-1:0] cnt;
  logic             pend;
  logic             flush_req;

  word_t            word_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;

  logic [CNT_W-1:0] lane_sum;
  logic [LW-1:0]    lane;
  logic             out_busy;
  logic             re;
  logic             cap_last;
  logic             flush_go;
  logic             flush_emit;

  // Lane the next pop will land in, counting the one in flight.
  assign lane_sum = cnt + CNT_W'(pend);
  assign lane = (lane_sum == CNT_W'(PACK))
              ? '0 : lane_sum[LW-1:0];

  assign out_busy = valid_q & ~bus.cB_ready_i;

  // Never pop a word's last entry unless the out reg
  // is free when that entry is captured.
  assign re = cB_rst_ni
            & bus.cB_rrdy_i
            & ~flush_req
            & ~((lane == LW'(LAST)) & out_busy);

  assign cap_last   = pend & (cnt == CNT_W'(LAST));
  assign flush_go   = flush_req & ~pend & ~out_busy;
  assign flush_emit = flush_go & (cnt != '0);

  always_comb begin
    full_word       = acc;
    full_word[LAST] = bus.cB_din_i;
  end

  always_ff @(posedge clkB_i or negedge cB_rst_ni) begin
    if (!cB_rst_ni) begin
      acc       <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      flush_req <= 1'b0;
      word_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      pend <= re;

      if (cap_last) begin
        acc <= '0;
        cnt <= '0;
      end else if (pend) begin
        acc[cnt[LW-1:0]] <= bus.cB_din_i;
        cnt <= cnt + CNT_W'(1);
      end else if (flush_emit) begin
        acc <= '0;
        cnt <= '0;
      end

      if (cap_last) begin
        word_q  <= full_word;
        cnt_q   <= CNT_W'(PACK);
        valid_q <= 1'b1;
      end else if (flush_emit) begin
        word_q  <= acc;
        cnt_q   <= cnt;
        valid_q <= 1'b1;
      end else if (valid_q && bus.cB_ready_i) begin
        valid_q <= 1'b0;
      end

      if (flush_go) begin
        flush_req <= 1'b0;
      end else if (bus.cB_flush_i) begin
        flush_req <= 1'b1;
      end
    end
  end

  assign bus.cB_re_o    = re;
  assign bus.cB_word_o  = word_q;
  assign bus.cB_cnt_o   = cnt_q;
  assign bus.cB_valid_o = valid_q;

endmodule
